// File: rtl/audio_pkg.sv
// Shared types for the audio frame buffer: sample type, bank status and reader states.
package audio_pkg;

    localparam int FRAME_LEN_DEF  = 256;
    localparam int DATA_WIDTH_DEF = 16;

    typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_stat_e;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank sample store: simple dual-port, 2*FRAME_LEN deep, one-cycle registered read.
// The address is {bank, index}; the read register resets so frame_data starts at zero.
module frame_bank_ram #(
    parameter int FRAME_LEN  = 256,
    parameter int DATA_WIDTH = 16,
    localparam int ADDR_W    = $clog2(FRAME_LEN) + 1
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic signed [DATA_WIDTH-1:0] mem [2*FRAME_LEN];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_frame_buffer.sv
// Ping-pong frame buffer: gathers decimator samples into FRAME_LEN frames and streams them
// out with valid/ready. Define AUDIO_FRAME_STATS_EN to add the saturating drop_count output.
module audio_frame_buffer
    import audio_pkg::*;
#(
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                         clk_in,
    input  logic                         rst_in_n,
    input  logic signed [DATA_WIDTH-1:0] audio_in,
    input  logic                         audio_sample_valid,
    output logic signed [DATA_WIDTH-1:0] frame_data,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         frame_last,
    output logic                         overflow,
    input  logic                         overflow_clr
`ifdef AUDIO_FRAME_STATS_EN
    ,
    output logic [15:0]                  drop_count
`endif
);

    localparam int               IDX_W   = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [1:0]       rst_sync;
    logic             rst_n;
    bank_stat_e       bank_st [2];
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    rd_state_e        rd_state;
    logic             drop;
    logic             wr_en;
    logic             wr_fill;
    logic             rd_xfer;
    logic             rd_free;
    logic             rd_en;
    logic [IDX_W:0]   rd_addr;

    // Assert asynchronously, release two clocks after rst_in_n rises.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign drop    = audio_sample_valid && (bank_st[wr_bank] == BANK_FULL);
    assign wr_en   = audio_sample_valid && !drop;
    assign wr_fill = wr_en && (wr_idx == IDX_MAX);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_en) begin
            wr_idx <= wr_fill ? '0 : wr_idx + IDX_ONE;
            if (wr_fill) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Writer only fills a FREE bank and reader only frees a FULL one, so they never collide.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= BANK_FREE;
            bank_st[1] <= BANK_FREE;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_fill && (int'(wr_bank) == b)) begin
                    bank_st[b] <= BANK_FULL;
                end else if (rd_free && (int'(rd_bank) == b)) begin
                    bank_st[b] <= BANK_FREE;
                end
            end
        end
    end

    assign frame_valid = (rd_state == RD_STREAM);
    assign frame_last  = frame_valid && (rd_idx == IDX_MAX);
    assign rd_xfer     = frame_valid && frame_ready;
    assign rd_free     = rd_xfer && frame_last;

    // RAM output is frame_data, so the next sample is fetched only on a transfer.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = {rd_bank, {IDX_W{1'b0}}};
        if (rd_state == RD_PRIME) begin
            rd_en = 1'b1;
        end else if (rd_xfer && !frame_last) begin
            rd_en   = 1'b1;
            rd_addr = {rd_bank, rd_idx + IDX_ONE};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_idx   <= '0;
            rd_bank  <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (bank_st[rd_bank] == BANK_FULL) begin
                        rd_state <= RD_PRIME;
                    end
                end
                RD_PRIME: begin
                    rd_state <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (rd_xfer) begin
                        if (frame_last) begin
                            rd_idx   <= '0;
                            rd_bank  <= ~rd_bank;
                            rd_state <= (bank_st[~rd_bank] == BANK_FULL) ? RD_PRIME : RD_IDLE;
                        end else begin
                            rd_idx <= rd_idx + IDX_ONE;
                        end
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear wins, so no lost sample goes unreported.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef AUDIO_FRAME_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (overflow_clr) begin
            drop_count <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            drop_count <= sat_inc(drop_count);
        end
    end
`endif

    frame_bank_ram #(
        .FRAME_LEN  (FRAME_LEN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, wr_idx}),
        .wr_data (audio_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (frame_data)
    );

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Self-checking bench for audio_frame_buffer: directed sequences, an overflow-clear vector
// table and randomized traffic, all scored against a queue-based frame model.
module tb_audio_frame_buffer;
    import audio_pkg::*;

    localparam int LEN = 256;

    logic    clk_in = 1'b0;
    logic    rst_in_n;
    sample_t audio_in;
    logic    audio_sample_valid;
    logic    frame_ready;
    logic    overflow_clr;
    sample_t frame_data;
    logic    frame_valid;
    logic    frame_last;
    logic    overflow;
`ifdef AUDIO_FRAME_STATS_EN
    logic [15:0] drop_count;
`endif

    always #5 clk_in = ~clk_in;

    audio_frame_buffer #(.FRAME_LEN(LEN), .DATA_WIDTH(16)) dut (
        .clk_in             (clk_in),
        .rst_in_n           (rst_in_n),
        .audio_in           (audio_in),
        .audio_sample_valid (audio_sample_valid),
        .frame_data         (frame_data),
        .frame_valid        (frame_valid),
        .frame_ready        (frame_ready),
        .frame_last         (frame_last),
        .overflow           (overflow),
        .overflow_clr       (overflow_clr)
`ifdef AUDIO_FRAME_STATS_EN
        ,
        .drop_count         (drop_count)
`endif
    );

    int      checks = 0;
    int      errors = 0;
    sample_t expq[$];
    sample_t partial[$];
    logic    exp_ovf;
    int      exp_drops;
    int      xfer_pos;
    int      cyc = 0;
    logic    prev_stall;
    sample_t prev_data;
    logic    prev_last;
    int      last_xfer_cyc;
    logic    gap_arm;
    int      gap_meas;

    typedef struct {
        logic sv;
        logic clr;
        logic exp_ovf;
    } ovf_vec_t;
    ovf_vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        expq.delete();
        partial.delete();
        exp_ovf    = 1'b0;
        exp_drops  = 0;
        xfer_pos   = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        gap_arm    = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, check outputs, advance the model.
    task automatic step(input logic sv, input sample_t d, input logic rdy, input logic clr);
        int   held;
        logic xfer;
        logic drop;
        audio_sample_valid = sv;
        audio_in           = d;
        frame_ready        = rdy;
        overflow_clr       = clr;
        #1;
        chk("overflow", overflow, exp_ovf);
`ifdef AUDIO_FRAME_STATS_EN
        chk("drop_count", drop_count, exp_drops);
`endif
        if (prev_stall) begin
            chk("hold_valid", frame_valid, 1);
            chk("hold_data", frame_data, prev_data);
            chk("hold_last", frame_last, prev_last);
        end
        if (gap_arm && frame_valid) begin
            gap_meas = cyc - last_xfer_cyc;
            gap_arm  = 1'b0;
        end
        if (expq.size() == 0) begin
            chk("idle_valid", frame_valid, 0);
        end else if (frame_valid) begin
            chk("frame_data", frame_data, expq[0]);
            chk("frame_last", frame_last, int'(xfer_pos == LEN - 1));
        end
        // Two frames waiting (complete, not fully read) means no free bank for the writer.
        held       = (expq.size() + LEN - 1) / LEN;
        drop       = sv && (held == 2);
        xfer       = frame_valid && rdy && (expq.size() > 0);
        prev_stall = frame_valid && !rdy;
        prev_data  = frame_data;
        prev_last  = frame_last;
        if (xfer) begin
            void'(expq.pop_front());
            if (xfer_pos == LEN - 1) begin
                xfer_pos      = 0;
                last_xfer_cyc = cyc;
                gap_arm       = (expq.size() > 0);
            end else begin
                xfer_pos++;
            end
        end
        if (sv && !drop) begin
            partial.push_back(d);
            if (partial.size() == LEN) begin
                foreach (partial[i]) expq.push_back(partial[i]);
                partial.delete();
            end
        end
        if (clr) exp_drops = drop ? 1 : 0;
        else if (drop && exp_drops < 65535) exp_drops++;
        exp_ovf = drop ? 1'b1 : (clr ? 1'b0 : exp_ovf);
        cyc++;
        @(negedge clk_in);
    endtask

    task automatic apply_reset();
        rst_in_n           = 1'b0;
        audio_sample_valid = 1'b0;
        frame_ready        = 1'b0;
        overflow_clr       = 1'b0;
        #1;
        chk("rst_valid", frame_valid, 0);
        chk("rst_last", frame_last, 0);
        chk("rst_data", frame_data, 0);
        chk("rst_overflow", overflow, 0);
`ifdef AUDIO_FRAME_STATS_EN
        chk("rst_drop_count", drop_count, 0);
`endif
        model_clear();
        repeat (3) @(negedge clk_in);
        rst_in_n = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (expq.size() > 0 && n < budget) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_complete", expq.size(), 0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rate;
        int rdy_pct;

        // Overflow expected one cycle after each row, starting from overflow=1 with both banks full.
        tbl[0] = '{1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1};

        rst_in_n           = 1'b0;
        audio_in           = '0;
        audio_sample_valid = 1'b0;
        frame_ready        = 1'b0;
        overflow_clr       = 1'b0;
        model_clear();
        repeat (2) @(negedge clk_in);
        apply_reset();

        // Ramp 0..255, one sample per 4 clocks, consumer always ready.
        for (int i = 0; i < LEN; i++) begin
            step(1'b1, sample_t'(i), 1'b1, 1'b0);
            if (i != LEN - 1) repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        end
        n = 0;
        while (!frame_valid && n < 10) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("first_valid_latency", n, 2);
        chk("first_sample", frame_data, 0);
        drain(LEN + 20);

        // One random frame, then drain with ready toggling every cycle.
        for (int i = 0; i < LEN; i++) step(1'b1, sample_t'($urandom), 1'b0, 1'b0);
        n = 0;
        while (expq.size() > 0 && n < 4 * LEN) begin
            step(1'b0, '0, 1'(n % 2), 1'b0);
            n++;
        end
        chk("toggle_drain_done", expq.size(), 0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);

        // Three frames into a stalled consumer: the third is dropped.
        for (int i = 0; i < 3 * LEN; i++) step(1'b1, sample_t'(i), 1'b0, 1'b0);
        chk("burst_overflow", overflow, 1);
`ifdef AUDIO_FRAME_STATS_EN
        chk("burst_drop_count", drop_count, 256);
`endif
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].sv, sample_t'(2000 + i), 1'b0, tbl[i].clr);
            chk("tbl_overflow", overflow, tbl[i].exp_ovf);
        end

        // Release the consumer: frames 0 and 1 back to back, nothing else.
        gap_meas = -1;
        drain(3 * LEN);
        checks++;
        if (gap_meas < 1 || gap_meas > 2) begin
            errors++;
            $display("FAIL frame_gap: got %0d cycles, expected 1..2", gap_meas);
        end

        // Full frame plus 100 samples, reset while streaming.
        for (int i = 0; i < LEN + 100; i++) step(1'b1, sample_t'(3000 + i), 1'b0, 1'b0);
        repeat (10) step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_reset_valid", frame_valid, 1);
        chk("pre_reset_overflow", overflow, 1);
        apply_reset();
        for (int i = 0; i < LEN; i++) step(1'b1, sample_t'(1000 + i), 1'b1, 1'b0);
        n = 0;
        while (!frame_valid && n < 10) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("post_reset_first", frame_data, 1000);
        drain(LEN + 20);

        // Randomized traffic in blocks of varying write rate and consumer readiness.
        for (int blk = 0; blk < 20; blk++) begin
            rate    = $urandom_range(1, 4);
            rdy_pct = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                step(1'($urandom_range(1, rate) == 1), sample_t'($urandom),
                     1'($urandom_range(0, 99) < rdy_pct), 1'($urandom_range(0, 40) == 0));
            end
        end
        drain(3 * LEN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_frame_buffer.md
AUDIO_FRAME_BUFFER -- requirements
Module: audio_frame_buffer

Interface
REQ-001 Parameter FRAME_LEN, default 256, samples per frame; power of two, 16..1024.
REQ-002 Parameter DATA_WIDTH, default 16, sample width, signed two's complement.
REQ-003 clk_in  input  1  system clock, 100 MHz; one clock; all logic on rising edge.
REQ-004 rst_in_n  input  1  reset, asynchronous assert, active-low.
REQ-005 audio_in  input  DATA_WIDTH  decimator output sample, signed.
REQ-006 audio_sample_valid  input  1  single-cycle strobe qualifying audio_in (decimator dec_output_ready).
REQ-007 frame_data  output  DATA_WIDTH  streamed frame sample, signed.
REQ-008 frame_valid  output  1  frame_data valid.
REQ-009 frame_ready  input  1  consumer accepts frame_data this cycle.
REQ-010 frame_last  output  1  high with the final (index FRAME_LEN-1) sample of a frame.
REQ-011 overflow  output  1  sticky, a sample was dropped.
REQ-012 overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-013 Two banks (ping-pong), each FRAME_LEN deep; each bank status FREE or FULL.
REQ-014 Writer stores audio_in at wr_idx of the current write bank on each audio_sample_valid; wr_idx increments.
REQ-015 At wr_idx == FRAME_LEN-1 the write marks the bank FULL, wr_idx wraps to 0, write bank toggles.
REQ-016 If audio_sample_valid arrives while write bank is FULL, sample dropped, wr_idx unchanged, overflow set next cycle.
REQ-017 Reader FSM states: IDLE, PRIME, STREAM.
REQ-018 IDLE -> PRIME when read bank is FULL; PRIME issues RAM read of address 0 (one-cycle read latency).
REQ-019 PRIME -> STREAM; frame_valid first asserts 2 cycles after the bank becomes FULL.
REQ-020 Transfer occurs when frame_valid && frame_ready; frame_data/frame_valid/frame_last hold stable while frame_valid && !frame_ready.
REQ-021 Sustained frame_ready gives one sample per cycle without bubbles within a frame.
REQ-022 On transfer with frame_last, read bank marked FREE, read bank toggles, FSM -> IDLE (or directly PRIME if the other bank is FULL).
REQ-023 Bank FULL (writer) and bank FREE (reader) in the same cycle on different banks both take effect.
REQ-024 Frames are emitted strictly in write order; sample order within a frame preserved.
REQ-025 overflow_clr and a new drop in the same cycle: overflow remains 1.

Reset
REQ-026 On rst_in_n low: frame_valid=0, frame_last=0, frame_data=0, overflow=0, both banks FREE, wr_idx=0, rd_idx=0, write and read bank = 0, FSM IDLE.
REQ-027 Reset mid-frame discards partial and pending frames; RAM contents need not be cleared.
REQ-028 Reset deassertion is synchronized to clk_in inside the block.

Configuration
REQ-029 Macro AUDIO_FRAME_STATS_EN defined: output drop_count (16 bits, saturating at 0xFFFF) counts dropped samples, cleared by overflow_clr or reset.
REQ-030 Without AUDIO_FRAME_STATS_EN: no drop_count port or logic; all other behaviour identical.

Structure
REQ-031 Shared package audio_pkg holds sample_t (signed DATA_WIDTH), bank status enum, reader state enum, default FRAME_LEN.
REQ-032 Storage is one sub-module frame_bank_ram: simple dual-port, 2*FRAME_LEN x DATA_WIDTH, registered read, address {bank, index}.

Verification
REQ-033 Feed 256 samples ramp 0..255 at one per 4 cycles, frame_ready=1 -> 256 transfers 0..255, frame_last only on 255, first frame_valid 2 cycles after 256th write.
REQ-034 frame_ready toggling 1/0 each cycle during a frame -> data unchanged while stalled, no loss, no duplication.
REQ-035 frame_ready=0, write 3 x 256 samples -> first 512 kept, samples 512..767 dropped, overflow=1, drop_count=256 (stats build); releasing ready yields frames 0 and 1 only.
REQ-036 overflow set, pulse overflow_clr -> overflow=0 next cycle; clr coincident with a drop -> overflow stays 1.
REQ-037 Assert rst_in_n low after 100 samples of a frame and during STREAM -> all outputs at reset values immediately; next frame starts at wr_idx 0.
REQ-038 Back-to-back full frames with frame_ready=1 continuously -> frame N+1 begins within 2 cycles of frame N frame_last transfer, order preserved.
